instruction_fetch_queue: RTL and testbench
==========================================

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, program-counter and instruction-address width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..64.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port imem_adr, output, ADDR_W, fetch address to the combinational program memory.
REQ-008 SHALL have port imem_instruction, input, DATA_W, word at imem_adr, valid in the same cycle.
REQ-009 SHALL have port out_valid, output, 1, queue head holds a valid instruction.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the head this cycle.
REQ-011 SHALL have port out_instruction, output, DATA_W, head instruction.
REQ-012 SHALL have port out_pc, output, ADDR_W, address the head instruction was fetched from.
REQ-013 SHALL have port redirect, input, 1, branch or jump taken; flush and refetch.
REQ-014 SHALL have port redirect_target, input, ADDR_W, new fetch address when redirect=1.
REQ-015 SHALL have port count, output, clog2(DEPTH)+1, current number of valid entries.

Function
REQ-016 SHALL hold fetch_pc and drive imem_adr=fetch_pc combinationally.
REQ-017 SHALL define pop = out_valid & out_ready, and push = !redirect & (count<DEPTH | pop).
REQ-018 SHALL, on push, write {imem_instruction, fetch_pc} at the tail and set fetch_pc <= fetch_pc+1 (word addressing, modulo 2^ADDR_W).
REQ-019 SHALL, on pop, advance the head; with no push, count decrements by 1.
REQ-020 SHALL, on simultaneous push and pop, leave count unchanged, including at count=DEPTH and count=1.
REQ-021 SHALL, when full and not popping, neither write nor advance fetch_pc.
REQ-022 SHALL, on redirect=1, clear all entries (count<=0), set fetch_pc <=redirect_target, suppress push, and ignore out_ready that cycle for queue state.
REQ-023 SHALL give redirect priority over push and pop in the same cycle.
REQ-024 SHALL assert out_valid iff count>0 (registered path); latency fetch-to-out_valid is 1 cycle.
REQ-025 SHALL wrap head and tail pointers modulo DEPTH without loss or duplication.
REQ-026 SHALL hold out_instruction and out_pc stable while out_valid=1 and out_ready=0.

Reset
REQ-027 SHALL, when reset_n=0 at a rising edge, set fetch_pc<=RESET_PC, count<=0, head<=0, tail<=0.
REQ-028 SHALL, during and immediately after reset, drive out_valid=0, count=0, imem_adr=RESET_PC; out_instruction/out_pc SHALL be 0 while empty.
REQ-029 SHALL give reset priority over redirect, push and pop; reset mid-stream discards all entries.

Configuration
REQ-030 SHALL compile a zero-latency bypass when macro FETCH_BYPASS_EN is defined.
REQ-031 SHALL, with FETCH_BYPASS_EN, when count=0 and redirect=0 and reset_n=1, drive out_valid=1, out_instruction=imem_instruction, out_pc=fetch_pc combinationally; if out_ready=1 the word is consumed without being stored and fetch_pc increments.
REQ-032 SHALL, without FETCH_BYPASS_EN, behave exactly per REQ-024, never presenting imem_instruction combinationally.

Verification
REQ-033 SHALL cover reset: reset_n=0 two cycles, release -> imem_adr=0, out_valid=0; next edge out_valid=1, out_pc=0 (non-bypass).
REQ-034 SHALL cover fill and backpressure: DEPTH=4, out_ready=0 -> after 4 edges count=4, imem_adr=4 held, out_pc=0 stable.
REQ-035 SHALL cover full streaming: count=4, out_ready=1 continuously -> count stays 4, out_pc sequence 0,1,2,3,4,... with no gaps.
REQ-036 SHALL cover redirect: count=3, redirect=1 and target=0x40 with out_ready=1 -> next cycle count=0, out_valid=0, imem_adr=0x40; following cycle out_pc=0x40.
REQ-037 SHALL cover wrap: ADDR_W=4, fetch from 0xE -> out_pc sequence 0xE, 0xF, 0x0, 0x1.
REQ-038 SHALL cover bypass: FETCH_BYPASS_EN, empty, out_ready=1 -> out_valid=1 in the first cycle after reset with out_pc=0, and count remains 0.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: fetches sequential words from a combinational imem into a small FIFO.
// Define FETCH_BYPASS_EN to present imem data combinationally while the queue is empty.
module instruction_fetch_queue #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  output logic [ADDR_W-1:0]        imem_adr,
  input  logic [DATA_W-1:0]        imem_instruction,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_instruction,
  output logic [ADDR_W-1:0]        out_pc,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_target,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL  = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [DATA_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0] q_pc    [DEPTH];

  logic q_valid;
  logic pop;
  logic push;
  logic q_pop;
  logic wr_en;
  logic bypass_take;

  assign imem_adr = fetch_pc;
  assign q_valid  = (count != '0);

`ifdef FETCH_BYPASS_EN
  logic bypass_on;
  assign bypass_on       = !q_valid && !redirect && reset_n;
  assign out_valid       = q_valid || bypass_on;
  assign out_instruction = q_valid ? q_instr[head] : (bypass_on ? imem_instruction : '0);
  assign out_pc          = q_valid ? q_pc[head]    : (bypass_on ? fetch_pc : '0);
  assign bypass_take     = bypass_on && out_ready;
`else
  assign out_valid       = q_valid;
  assign out_instruction = q_valid ? q_instr[head] : '0;
  assign out_pc          = q_valid ? q_pc[head]    : '0;
  assign bypass_take     = 1'b0;
`endif

  assign pop   = out_valid && out_ready;
  assign push  = !redirect && ((count < FULL) || pop);
  // A bypassed word advances fetch_pc but never occupies a slot.
  assign q_pop = pop && q_valid && !redirect;
  assign wr_en = push && !bypass_take;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_target;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (push)  fetch_pc <= fetch_pc + ADDR_W'(1);
      if (wr_en) tail     <= tail + PTR_W'(1);
      if (q_pop) head     <= head + PTR_W'(1);
      case ({wr_en, q_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && wr_en) begin
      q_instr[tail] <= imem_instruction;
      q_pc[tail]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: a default-width queue plus a 4-bit-address
// instance for pc wrap. Bypass expectations follow FETCH_BYPASS_EN when it is defined.
module tb_instruction_fetch_queue;

`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  always #5 clock = ~clock;

  logic [31:0] adr_a, instr_a, oinstr_a, opc_a, target_a;
  logic        valid_a, ready_a, redirect_a;
  logic [2:0]  count_a;

  logic [3:0]  adr_b, opc_b, target_b;
  logic [7:0]  instr_b, oinstr_b;
  logic        valid_b, ready_b, redirect_b;
  logic [2:0]  count_b;

  assign instr_a = 32'hA500_0000 ^ adr_a;
  assign instr_b = {4'h5, adr_b};

  instruction_fetch_queue u_dut_a (
    .clock(clock), .reset_n(reset_n), .imem_adr(adr_a), .imem_instruction(instr_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_instruction(oinstr_a), .out_pc(opc_a),
    .redirect(redirect_a), .redirect_target(target_a), .count(count_a)
  );

  instruction_fetch_queue #(.DATA_W(8), .ADDR_W(4), .DEPTH(4)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .imem_adr(adr_b), .imem_instruction(instr_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_instruction(oinstr_b), .out_pc(opc_b),
    .redirect(redirect_b), .redirect_target(target_b), .count(count_b)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] ia(input logic [31:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  initial begin
    reset_n = 1'b0; ready_a = 1'b0; redirect_a = 1'b0; target_a = '0;
    ready_b = 1'b0; redirect_b = 1'b0; target_b = '0;
    step(); step();
    check("rst_count", count_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_adr",   adr_a,   0);

    reset_n = 1'b1; #1;
    check("rel_valid", valid_a, BYP);
    check("rel_adr",   adr_a,   0);
    check("rel_pc",    opc_a,   0);
    check("rel_count", count_a, 0);

    step();
    check("first_valid", valid_a,  1);
    check("first_pc",    opc_a,    0);
    check("first_instr", oinstr_a, ia(0));
    check("first_count", count_a,  1);
    check("first_adr",   adr_a,    1);

    step(); step(); step();
    check("fill_count", count_a, 4);
    check("fill_adr",   adr_a,   4);
    step();
    check("full_count", count_a, 4);
    check("full_adr",   adr_a,   4);
    check("full_pc",    opc_a,   0);

    ready_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("stream_pc",    opc_a,    k);
      check("stream_instr", oinstr_a, ia(k));
      step();
      check("stream_count", count_a,  4);
    end
    ready_a = 1'b0; #1;
    check("stream_adr",  adr_a, 12);
    check("stream_head", opc_a, 8);

    redirect_a = 1'b1; target_a = 32'h20; ready_a = 1'b1;
    step();
    redirect_a = 1'b0; ready_a = 1'b0; #1;
    check("redir1_count", count_a, 0);
    check("redir1_valid", valid_a, BYP);
    check("redir1_adr",   adr_a,   32'h20);
    check("redir1_pc",    opc_a,   BYP ? 32'h20 : 32'h0);
    step(); step(); step();
    check("c3_count", count_a, 3);
    check("c3_pc",    opc_a,   32'h20);
    check("c3_adr",   adr_a,   32'h23);

    redirect_a = 1'b1; target_a = 32'h40; ready_a = 1'b1;
    step();
    redirect_a = 1'b0; ready_a = 1'b0; #1;
    check("redir2_count", count_a, 0);
    check("redir2_valid", valid_a, BYP);
    check("redir2_adr",   adr_a,   32'h40);
    step();
    check("redir2_pc",    opc_a,    32'h40);
    check("redir2_instr", oinstr_a, ia(32'h40));
    check("redir2_vld",   valid_a,  1);
    check("redir2_cnt1",  count_a,  1);
    step();
    check("hold_pc",    opc_a,   32'h40);
    check("hold_count", count_a, 2);

    reset_n = 1'b0; redirect_a = 1'b1; target_a = 32'h99; ready_a = 1'b1;
    step();
    check("mrst_count", count_a, 0);
    check("mrst_adr",   adr_a,   0);
    check("mrst_valid", valid_a, 0);
    redirect_a = 1'b0; ready_a = 1'b0; reset_n = 1'b1;
    step();
    check("mrst_refill", count_a, 1);
    check("mrst_pc",     opc_a,   0);

`ifdef FETCH_BYPASS_EN
    reset_n = 1'b0;
    step();
    reset_n = 1'b1; ready_a = 1'b1; #1;
    check("byp_valid", valid_a,  1);
    check("byp_pc",    opc_a,    0);
    check("byp_instr", oinstr_a, ia(0));
    check("byp_count", count_a,  0);
    step();
    check("byp_count2", count_a, 0);
    check("byp_adr",    adr_a,   1);
    check("byp_pc2",    opc_a,   1);
    ready_a = 1'b0;
`endif

    redirect_b = 1'b1; target_b = 4'hE; ready_b = 1'b0;
    step();
    redirect_b = 1'b0; #1;
    check("wrap_adr0", adr_b, 4'hE);
    step(); step(); step(); step();
    check("wrap_count", count_b, 4);
    check("wrap_adr",   adr_b,   4'h2);
    ready_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("wrap_pc",    opc_b,    (4'hE + k) & 4'hF);
      check("wrap_instr", oinstr_b, {4'h5, 4'((4'hE + k) & 4'hF)});
      step();
    end
    check("wrap_count2", count_b, 4);
    ready_b = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
